// File: rtl/bchecc_enc_ctrl.sv
// BCH ECC encoder control: streams message bits through an external LFSR step,
// then shifts out the accumulated parity LSB-first.
module bchecc_enc_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [15:0]  msg_len_i,
    input  logic [7:0]   par_len_i,
    input  logic [194:0] gen_poly_i,
    input  logic         din_i,
    input  logic         din_vld_i,
    output logic         din_rdy_o,
    output logic         dout_o,
    output logic         dout_vld_o,
    input  logic         dout_rdy_i,
    output logic         dout_last_o,
    output logic         mod_data_o,
    output logic [194:0] mod_ecc_r_o,
    output logic [194:0] mod_gen_poly_o,
    input  logic [194:0] mod_ecc_r_i,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {IDLE, MSG, PAR, DONE} state_e;

    state_e       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  msg_len_q, msg_len_d;
    logic [7:0]   par_len_q, par_len_d;
    logic [194:0] ecc_q, ecc_d;
    logic [194:0] poly_q, poly_d;
    logic         msg_last;
    logic         par_last;
    logic         xfer;

    assign msg_last = (cnt_q == msg_len_q - 16'd1);
    assign par_last = (cnt_q == {8'd0, par_len_q} - 16'd1);

    always_comb begin
        din_rdy_o  = 1'b0;
        dout_o     = 1'b0;
        dout_vld_o = 1'b0;
        mod_data_o = 1'b0;
        unique case (state_q)
            MSG: begin
                dout_o     = din_i;
                dout_vld_o = din_vld_i;
                din_rdy_o  = dout_rdy_i;
                mod_data_o = din_i;
            end
            PAR: begin
                dout_vld_o = 1'b1;
                dout_o     = ecc_q[0];
            end
            default: ;
        endcase
    end

    assign xfer           = dout_vld_o & dout_rdy_i;
    assign dout_last_o    = (state_q == PAR) && par_last;
    assign mod_ecc_r_o    = ecc_q;
    assign mod_gen_poly_o = poly_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ecc_d     = ecc_q;
        msg_len_d = msg_len_q;
        par_len_d = par_len_q;
        poly_d    = poly_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ecc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    msg_len_d = msg_len_i;
                    // Out-of-range parity counts fall back to the full register
                    par_len_d = (par_len_i == 8'd0 || par_len_i > 8'd195)
                              ? 8'd195 : par_len_i;
                    poly_d    = gen_poly_i;
                    cnt_d     = '0;
                    ecc_d     = '0;
                    state_d   = (msg_len_i == 16'd0) ? PAR : MSG;
                end
                MSG: if (xfer) begin
                    ecc_d = mod_ecc_r_i;
                    if (msg_last) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                PAR: if (xfer) begin
                    ecc_d = {1'b0, ecc_q[194:1]};
                    cnt_d = cnt_q + 16'd1;
                    if (par_last) state_d = DONE;
                end
                DONE: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ecc_q     <= '0;
            msg_len_q <= '0;
            par_len_q <= '0;
            poly_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ecc_q     <= ecc_d;
            msg_len_q <= msg_len_d;
            par_len_q <= par_len_d;
            poly_q    <= poly_d;
        end
    end

endmodule

// File: tb/tb_bchecc_enc_ctrl.sv
// Scoreboard bench for bchecc_enc_ctrl with a behavioural LFSR step attached.
module tb_bchecc_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         abort_i;
    logic [15:0]  msg_len_i;
    logic [7:0]   par_len_i;
    logic [194:0] gen_poly_i;
    logic         din_i;
    logic         din_vld_i;
    logic         din_rdy_o;
    logic         dout_o;
    logic         dout_vld_o;
    logic         dout_rdy_i;
    logic         dout_last_o;
    logic         mod_data_o;
    logic [194:0] mod_ecc_r_o;
    logic [194:0] mod_gen_poly_o;
    logic [194:0] mod_ecc_r_i;
    logic         busy_o;
    logic         done_o;

    int vecs = 0;
    int miss = 0;
    logic [1:0] sb_q[$];
    bit msg_bits[$];

    always #5 clk = ~clk;

    // External LFSR step: divide by gen_poly, LSB-first remainder
    assign mod_ecc_r_i = (mod_ecc_r_o >> 1)
                       ^ ((mod_data_o ^ mod_ecc_r_o[0]) ? mod_gen_poly_o : '0);

    bchecc_enc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .msg_len_i(msg_len_i), .par_len_i(par_len_i), .gen_poly_i(gen_poly_i),
        .din_i(din_i), .din_vld_i(din_vld_i), .din_rdy_o(din_rdy_o),
        .dout_o(dout_o), .dout_vld_o(dout_vld_o), .dout_rdy_i(dout_rdy_i),
        .dout_last_o(dout_last_o), .mod_data_o(mod_data_o),
        .mod_ecc_r_o(mod_ecc_r_o), .mod_gen_poly_o(mod_gen_poly_o),
        .mod_ecc_r_i(mod_ecc_r_i), .busy_o(busy_o), .done_o(done_o)
    );

    function automatic logic [194:0] rand_poly();
        logic [223:0] w;
        for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
        return w[194:0] | 195'h1;
    endfunction

    // Push up to maxn expected {bit,last} pairs of the codeword
    function automatic void build_exp(input int mlen, input int plen,
                                      input logic [194:0] poly, input int maxn);
        logic [194:0] e;
        int ep;
        int n;
        bit fb;
        e = '0;
        n = 0;
        for (int i = 0; i < mlen; i++) begin
            if (n < maxn) sb_q.push_back({msg_bits[i], 1'b0});
            n++;
            fb = msg_bits[i] ^ e[0];
            e = (e >> 1) ^ (fb ? poly : '0);
        end
        ep = (plen == 0 || plen > 195) ? 195 : plen;
        for (int i = 0; i < ep; i++) begin
            if (n < maxn) sb_q.push_back({e[0], (i == ep - 1)});
            n++;
            e = e >> 1;
        end
    endfunction

    task automatic run_cw(input string nm, input int mlen, input int plen,
                          input logic [194:0] poly, input bit stall);
        int idx;
        int dn;
        bit acc;
        bit fin;
        bit hold;
        logic [194:0] ep;
        logic [1:0] e;
        idx = 0;
        dn = 0;
        fin = 0;
        build_exp(mlen, plen, poly, 100000);
        msg_len_i = mlen[15:0];
        par_len_i = plen[7:0];
        gen_poly_i = poly;
        start_i = 1'b1;
        din_vld_i = 1'b1;
        din_i = 1'b1;
        dout_rdy_i = 1'b1;
        @(negedge clk);
        vecs++;
        if (din_rdy_o !== 1'b0 || dout_vld_o !== 1'b0) begin
            miss++;
            $display("FAIL %s start_cycle: rdy=%b vld=%b required 0 0",
                     nm, din_rdy_o, dout_vld_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            din_vld_i = (idx < mlen);
            din_i = (idx < mlen) ? msg_bits[idx] : 1'b0;
            dout_rdy_i = stall ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            acc = din_vld_i && din_rdy_o;
            hold = busy_o && !(dout_vld_o && dout_rdy_i);
            ep = mod_ecc_r_o;
            if (dout_vld_o && dout_rdy_i) begin
                vecs++;
                if (sb_q.size() == 0) begin
                    miss++;
                    $display("FAIL %s stream_extra: dout=%b, none expected",
                             nm, dout_o);
                end else begin
                    e = sb_q.pop_front();
                    if ({dout_o, dout_last_o} !== e) begin
                        miss++;
                        $display("FAIL %s stream: dout,last=%b%b required %b%b",
                                 nm, dout_o, dout_last_o, e[1], e[0]);
                    end
                end
            end
            if (done_o) begin
                dn++;
                fin = 1;
            end
            @(posedge clk); #1;
            if (hold) begin
                vecs++;
                if (mod_ecc_r_o !== ep) begin
                    miss++;
                    $display("FAIL %s ecc_hold: ecc=%h required %h",
                             nm, mod_ecc_r_o, ep);
                end
            end
            if (acc) idx++;
        end
        din_vld_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        vecs++;
        if (!fin || dn != 1 || busy_o !== 1'b0 || sb_q.size() != 0) begin
            miss++;
            $display("FAIL %s done: pulses=%0d busy=%b left=%0d required 1 0 0",
                     nm, dn, busy_o, sb_q.size());
        end
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b1;
        abort_i = 1'b0;
        msg_len_i = 16'd4;
        par_len_i = 8'd4;
        gen_poly_i = rand_poly();
        din_i = 1'b1;
        din_vld_i = 1'b1;
        dout_rdy_i = 1'b1;
        #12;
        vecs++;
        if ({busy_o, done_o, din_rdy_o, dout_vld_o, dout_o, dout_last_o,
             mod_data_o} !== 7'd0 || mod_ecc_r_o !== '0 || mod_gen_poly_o !== '0) begin
            miss++;
            $display("FAIL reset_outputs: ctl=%b ecc=%h poly=%h required 0",
                     {busy_o, done_o, din_rdy_o, dout_vld_o, dout_o, dout_last_o,
                      mod_data_o}, mod_ecc_r_o, mod_gen_poly_o);
        end
        start_i = 1'b0;
        #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++;
            if (din_rdy_o !== 1'b0 || dout_vld_o !== 1'b0 || busy_o !== 1'b0) begin
                miss++;
                $display("FAIL no_start_xfer: rdy=%b vld=%b busy=%b required 0",
                         din_rdy_o, dout_vld_o, busy_o);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        msg_bits = '{1'b1};
        run_cw("single", 1, 3, 195'h1, 1'b0);
    endtask

    task automatic test_two();
        msg_bits = '{1'b1, 1'b1};
        run_cw("two", 2, 2, 195'h3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [194:0] p;
        p = rand_poly();
        msg_bits.delete();
        for (int i = 0; i < 20; i++) msg_bits.push_back(1'($urandom));
        run_cw("b2b_free", 20, 16, p, 1'b0);
        run_cw("b2b_stall", 20, 16, p, 1'b1);
        msg_bits = '{1'b1};
        run_cw("single_stall", 1, 3, 195'h1, 1'b1);
    endtask

    task automatic test_edge_len();
        msg_bits.delete();
        run_cw("len0", 0, 0, rand_poly(), 1'b0);
        msg_bits = '{1'b1, 1'b0, 1'b1};
        run_cw("par250", 3, 250, rand_poly(), 1'b1);
    endtask

    task automatic test_abort();
        int n;
        logic [1:0] e;
        msg_bits = '{1'b1};
        build_exp(1, 10, 195'h5, 6);
        msg_len_i = 16'd1;
        par_len_i = 8'd10;
        gen_poly_i = 195'h5;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            din_vld_i = 1'b1;
            din_i = 1'b1;
            dout_rdy_i = 1'b1;
            @(negedge clk);
            if (dout_vld_o && dout_rdy_i) begin
                n++;
                vecs++;
                e = sb_q.pop_front();
                if ({dout_o, dout_last_o} !== e) begin
                    miss++;
                    $display("FAIL abort stream: dout,last=%b%b required %b%b",
                             dout_o, dout_last_o, e[1], e[0]);
                end
            end
            @(posedge clk); #1;
        end
        din_vld_i = 1'b0;
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        vecs++;
        if (n != 6 || busy_o !== 1'b0 || done_o !== 1'b0 || dout_vld_o !== 1'b0
            || mod_ecc_r_o !== '0) begin
            miss++;
            $display("FAIL abort_state: n=%0d busy=%b done=%b vld=%b ecc=%h required 6 0 0 0 0",
                     n, busy_o, done_o, dout_vld_o, mod_ecc_r_o);
        end
        @(negedge clk);
        vecs++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miss++;
            $display("FAIL abort_no_done: done=%b busy=%b required 0 0",
                     done_o, busy_o);
        end
        sb_q.delete();
        @(posedge clk); #1;
        msg_bits = '{1'b1};
        run_cw("restart", 1, 3, 195'h1, 1'b0);
    endtask

    task automatic test_async_reset();
        int n;
        logic [1:0] e;
        logic [194:0] p;
        p = rand_poly();
        msg_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        build_exp(10, 8, p, 3);
        msg_len_i = 16'd10;
        par_len_i = 8'd8;
        gen_poly_i = p;
        start_i = 1'b1;
        @(posedge clk); #1;
        gen_poly_i = ~p;
        msg_len_i = 16'd0;
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            din_vld_i = 1'b1;
            din_i = msg_bits[n];
            dout_rdy_i = 1'b1;
            @(negedge clk);
            vecs++;
            if (mod_gen_poly_o !== p || busy_o !== 1'b1) begin
                miss++;
                $display("FAIL start_ignored: poly=%h busy=%b required %h 1",
                         mod_gen_poly_o, busy_o, p);
            end
            if (dout_vld_o && dout_rdy_i) begin
                n++;
                vecs++;
                e = sb_q.pop_front();
                if ({dout_o, dout_last_o} !== e) begin
                    miss++;
                    $display("FAIL areset stream: dout,last=%b%b required %b%b",
                             dout_o, dout_last_o, e[1], e[0]);
                end
            end
            @(posedge clk); #1;
        end
        din_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({busy_o, done_o, din_rdy_o, dout_vld_o, dout_o, dout_last_o,
             mod_data_o} !== 7'd0 || mod_ecc_r_o !== '0 || mod_gen_poly_o !== '0) begin
            miss++;
            $display("FAIL async_reset: ctl=%b ecc=%h poly=%h required 0",
                     {busy_o, done_o, din_rdy_o, dout_vld_o, dout_o, dout_last_o,
                      mod_data_o}, mod_ecc_r_o, mod_gen_poly_o);
        end
        start_i = 1'b0;
        #4 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vecs++;
            if (din_rdy_o !== 1'b0 || dout_vld_o !== 1'b0) begin
                miss++;
                $display("FAIL post_reset_idle: rdy=%b vld=%b required 0 0",
                         din_rdy_o, dout_vld_o);
            end
        end
        din_vld_i = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_back_to_back();
        test_edge_len();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/bchecc_enc_ctrl.md
BCHECC_ENC_CTRL -- requirements
Module: bchecc_enc_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports listed first: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL provide these control ports: start_i  input  1  begin codeword, sampled in IDLE only; abort_i  input  1  synchronous cancel; msg_len_i  input  16  message bit count, latched at start; par_len_i  input  8  parity bit count, latched at start; gen_poly_i  input  195  generator polynomial, latched at start.
REQ-003 The block SHALL provide these stream ports: din_i  input  1  message bit; din_vld_i  input  1  message bit valid; din_rdy_o  output  1  message bit accepted; dout_o  output  1  codeword bit; dout_vld_o  output  1  codeword bit valid; dout_rdy_i  input  1  sink ready; dout_last_o  output  1  final codeword bit.
REQ-004 The block SHALL provide these datapath ports to the external LFSR step: mod_data_o  output  1  bit fed to the step; mod_ecc_r_o  output  195  current remainder register; mod_gen_poly_o  output  195  latched polynomial; mod_ecc_r_i  input  195  next remainder returned by the step.
REQ-005 The block SHALL provide these status ports: busy_o  output  1  state is not IDLE; done_o  output  1  one-cycle pulse on codeword completion.

Function
REQ-006 The block SHALL implement states IDLE, MSG, PAR and DONE, with a 16-bit bit counter cnt and a 195-bit remainder register ecc_r.
REQ-007 In IDLE with start_i=1, the block SHALL do the following on that edge: latch msg_len_i, par_len_i and gen_poly_i; clear ecc_r and cnt to 0; go to MSG, or go to PAR if msg_len_i=0.
REQ-008 The block SHALL treat a latched par_len of 0 or greater than 195 as 195.
REQ-009 In MSG, the block SHALL drive dout_o=din_i, dout_vld_o=din_vld_i and din_rdy_o=dout_rdy_i combinationally, so that a transfer occurs when din_vld_i and dout_rdy_i are both 1.
REQ-010 In MSG, mod_data_o SHALL equal din_i; in all other states mod_data_o SHALL be 0.
REQ-011 mod_ecc_r_o SHALL equal ecc_r, and mod_gen_poly_o SHALL equal the latched polynomial, at all times.
REQ-012 On each MSG transfer, the block SHALL load ecc_r from mod_ecc_r_i and increment cnt.
REQ-013 On the MSG transfer where cnt=msg_len-1, the block SHALL clear cnt and go to PAR.
REQ-014 In MSG with no transfer, ecc_r and cnt SHALL hold.
REQ-015 In PAR, the block SHALL drive dout_vld_o=1, dout_o=ecc_r[0] and din_rdy_o=0.
REQ-016 On each PAR transfer (dout_rdy_i=1), the block SHALL load ecc_r with {1'b0, ecc_r[194:1]} and increment cnt.
REQ-017 On the PAR transfer where cnt=par_len-1, the block SHALL go to DONE.
REQ-018 dout_last_o SHALL be 1 only in PAR with cnt=par_len-1.
REQ-019 In DONE, the block SHALL assert done_o for exactly one cycle, then go to IDLE; no stream transfers SHALL occur in DONE.
REQ-020 In IDLE and DONE, din_rdy_o and dout_vld_o SHALL be 0.
REQ-021 The block SHALL ignore start_i outside IDLE.
REQ-022 abort_i=1 in any state SHALL force IDLE and clear cnt and ecc_r on the next edge, with no done_o pulse; abort_i SHALL take priority over start_i and over any transfer in the same cycle.
REQ-023 Latency: the first message bit SHALL be accepted no earlier than the cycle after start_i; the first parity bit SHALL be valid in the cycle after the last message transfer.
REQ-024 Latched length and polynomial values SHALL NOT change while busy_o=1.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force state IDLE, cnt=0, ecc_r=0 and latched polynomial=0, with all outputs 0, including while a codeword is mid-operation.
REQ-026 After rst_n deasserts, the block SHALL require a new start_i before any transfer occurs.

Verification
REQ-027 Single bit: gen_poly=195'h1, msg_len=1, par_len=3, din=1, dout_rdy=1 -> dout sequence 1,1,0,0; dout_last_o on the 4th bit; done_o one cycle later.
REQ-028 Two bits: gen_poly=195'h3, msg_len=2, par_len=2, din sequence 1,1 -> ecc_r=3 then 1; dout sequence 1,1,1,0.
REQ-029 Backpressure: dout_rdy_i toggled 1,0,1,0 during both MSG and PAR -> identical output sequence to the unstalled run; ecc_r holds in stall cycles.
REQ-030 Edge lengths: msg_len=0, par_len=0 -> the block enters PAR directly and emits 195 zero bits, then done_o.
REQ-031 Abort and restart: abort_i asserted in PAR after 5 parity bits -> IDLE next cycle, busy_o=0, no done_o; a new start_i with the single-bit case of REQ-027 -> correct sequence 1,1,0,0.
REQ-032 Async reset: rst_n pulsed low mid-MSG asynchronously to clk -> all outputs 0 immediately; start_i held high in non-IDLE states -> ignored.
